lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store unit that consumes the decoder's memory controls (mem_rd, mem_wr, rw_type = funct3) plus the ALU-computed address and store data. It runs a registered request/grant/response handshake to a word-addressed data memory and generates byte enables and lane-replicated store data. It returns sign- or zero-extended load data and a stall to the pipeline, and reports misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT, 255, cycles allowed waiting for dmem_gnt, or for dmem_rvalid after grant, before abort (>=1)
ERR_RDATA, 32'h0000_0000, rdata value returned with any nonzero rsp_err

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  pipeline presents a memory op this cycle
mem_rd  in  1  load request (decoder)
mem_wr  in  1  store request (decoder)
rw_type  in  3  funct3: load 0=lb 1=lh 2=lw 4=lbu 5=lhu; store 0=sb 1=sh 2=sw
addr  in  32  byte address
wdata  in  32  store data (rs2)
req_ready  out  1  high only in IDLE
stall  out  1  req_valid & ~rsp_valid (combinational); pipeline freezes
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  2  0 ok, 1 misaligned, 2 timeout, 3 illegal
rdata  out  32  extended load data; 0 for stores; valid with rsp_valid
dmem_req  out  1  memory request, held until grant
dmem_we  out  1  1 = write
dmem_addr  out  32  {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid; earliest the cycle after gnt
dmem_rdata  in  32  read word

Behaviour:
- Reset (async, immediate): state=IDLE. dmem_req, dmem_we, rsp_valid = 0; rsp_err=0; rdata=0; dmem_addr, dmem_be, dmem_wdata = 0; timeout counter=0.
- Reset mid-transaction: dmem_req drops at once. The outstanding access is abandoned. A dmem_rvalid or dmem_gnt arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT_R, RESP. All dmem_* and rsp_* outputs are registered.
- Acceptance: req_valid & IDLE. addr, rw_type and wdata are latched. Classification, in priority order:
  - mem_rd==mem_wr → illegal (3).
  - Load with rw_type in {3,6,7}, or store with rw_type > 2 → illegal (3).
  - Halfword with addr[0]=1, or word with addr[1:0]≠0 → misaligned (1).
  - Any error → RESP next cycle. No dmem_req is issued. rdata=ERR_RDATA.
  - Otherwise → REQ, with dmem_req=1 in the next cycle.
- REQ: dmem_req, dmem_we, addr, be and wdata are held stable until dmem_gnt.
  - Store grant → RESP.
  - Load grant → WAIT_R.
  - dmem_rvalid seen in REQ is ignored.
- WAIT_R: on dmem_rvalid, register the extracted data and go to RESP.
  - Extraction: lane = addr[1:0]. Byte = rdata[8*lane+:8]; half = rdata[16*addr[1]+:16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready stays 0.
- A back-to-back request is accepted the cycle after RESP, i.e. in IDLE.
- Store lanes:
  - sb: be=4'b0001<<lane, wdata={4{wdata[7:0]}}.
  - sh: be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}.
  - sw: be=1111.
  - Loads: be=1111, we=0.
- Timeout: the counter clears on entry to REQ and on dmem_gnt, and increments each cycle in REQ or WAIT_R. When count==TIMEOUT-1 and the awaited event is absent, the transaction aborts: dmem_req→0, go to RESP with rsp_err=2, rdata=ERR_RDATA.
- Counter width: $clog2(TIMEOUT+1), with no wrap.
- Latency at full speed, with request accepted at cycle 0 and gnt in the first REQ cycle:
  - Store: rsp_valid at cycle 2.
  - Load with rvalid at cycle 2: rsp_valid at cycle 3.
  - Error: rsp_valid at cycle 1.
- rw_type and inputs are ignored outside IDLE. The pipeline must hold them stable anyway while stalled.

Decomposition:
- Shared package (lsu_pkg): funct3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW), rsp_err codes, state encoding.
- One combinational sub-module, lsu_align: (rw_type, addr[1:0], wdata, dmem_rdata) → (be, wdata_lanes, load_ext, misaligned, illegal).
- The FSM and timeout counter stay in lsu_mem_ctrl.

Test Plan:
- sb addr=0x1003, wdata=0xA5, gnt immediate → dmem_addr=0x1000, be=1000, dmem_wdata=0xA5A5A5A5, rsp_valid at cycle 2, err=0.
- lb addr=0x2001, dmem_rdata=0x1234_80FF → rdata=0xFFFF_FF80; lbu same → 0x0000_0080; lhu addr=0x2002 → 0x0000_1234.
- lw addr=0x3002 → no dmem_req, rsp_valid cycle 1, rsp_err=1, rdata=0; mem_rd=mem_wr=1 → rsp_err=3; load rw_type=3 → rsp_err=3.
- TIMEOUT=4, gnt never asserted → dmem_req high 4 cycles then low, rsp_err=2; repeat with gnt but no rvalid → same abort from WAIT_R.
- gnt delayed 3 cycles on sh addr=0x4002 wdata=0xBEEF → dmem_req/be=1100/wdata=0xBEEFBEEF stable throughout; stall high until rsp_valid.
- rst_n low during WAIT_R, then a late rvalid → dmem_req=0 immediately, no rsp_valid; next lw completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access types, response
// error codes and controller state encoding.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational lane logic: byte enables, store-data replication, load
// extraction/extension and access classification (misaligned / illegal).
module lsu_align
  import lsu_pkg::*;
(
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  rw_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_ext,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_half = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be          = '1;
    wdata_lanes = wdata;
    load_ext    = rdata;
    misaligned  = 1'b0;
    illegal     = 1'b0;
    if (mem_rd == mem_wr) begin
      illegal = 1'b1;
    end else if (mem_wr) begin
      case (rw_type)
        SB: begin
          be          = 4'b0001 << addr_lo;
          wdata_lanes = {4{wdata[7:0]}};
        end
        SH: begin
          be          = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_lanes = {2{wdata[15:0]}};
          misaligned  = addr_lo[0];
        end
        SW: begin
          be         = 4'b1111;
          misaligned = |addr_lo;
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (rw_type)
        LB:  load_ext = {{24{lane_byte[7]}}, lane_byte};
        LBU: load_ext = {24'h00_0000, lane_byte};
        LH: begin
          load_ext   = {{16{lane_half[15]}}, lane_half};
          misaligned = addr_lo[0];
        end
        LHU: begin
          load_ext   = {16'h0000, lane_half};
          misaligned = addr_lo[0];
        end
        LW:  misaligned = |addr_lo;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit controller: request/grant/response handshake to a
// word-addressed data memory with timeout abort and registered outputs.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  rw_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        rsp_valid,
  output logic [1:0]  rsp_err,
  output logic [31:0] rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic [2:0]    f3_q, f3_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          dmem_req_q, dmem_req_d;
  logic          dmem_we_q, dmem_we_d;
  logic [31:0]   dmem_addr_q, dmem_addr_d;
  logic [3:0]    dmem_be_q, dmem_be_d;
  logic [31:0]   dmem_wdata_q, dmem_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [1:0]    rsp_err_q, rsp_err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          in_idle;
  logic          al_rd, al_wr;
  logic [2:0]    al_f3;
  logic [1:0]    al_lo;
  logic [3:0]    al_be;
  logic [31:0]   al_wlanes, al_load;
  logic          al_mis, al_ill;

  assign in_idle = (state_q == ST_IDLE);

  // One align instance serves both phases: live inputs classify and lane the
  // request at acceptance; latched fields drive load extraction afterwards.
  assign al_rd = in_idle ? mem_rd        : rd_q;
  assign al_wr = in_idle ? mem_wr        : wr_q;
  assign al_f3 = in_idle ? rw_type       : f3_q;
  assign al_lo = in_idle ? addr[1:0]     : addr_lo_q;

  lsu_align u_align (
    .mem_rd      (al_rd),
    .mem_wr      (al_wr),
    .rw_type     (al_f3),
    .addr_lo     (al_lo),
    .wdata       (wdata),
    .rdata       (dmem_rdata),
    .be          (al_be),
    .wdata_lanes (al_wlanes),
    .load_ext    (al_load),
    .misaligned  (al_mis),
    .illegal     (al_ill)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_lo_d    = addr_lo_q;
    f3_d         = f3_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = rsp_err_q;
    rdata_d      = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_lo_d = addr[1:0];
          f3_d      = rw_type;
          rd_d      = mem_rd;
          wr_d      = mem_wr;
          if (al_ill || al_mis) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = al_ill ? ERR_ILLEGAL : ERR_MISALIGN;
            rdata_d     = ERR_RDATA;
          end else begin
            state_d      = ST_REQ;
            cnt_d        = '0;
            dmem_req_d   = 1'b1;
            dmem_we_d    = mem_wr;
            dmem_addr_d  = {addr[31:2], 2'b00};
            dmem_be_d    = al_be;
            dmem_wdata_d = al_wlanes;
          end
        end
      end

      ST_REQ: begin
        if (dmem_gnt) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          cnt_d      = '0;
          if (wr_q) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_NONE;
            rdata_d     = '0;
          end else begin
            state_d = ST_WAIT_R;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_RESP;
          dmem_req_d  = 1'b0;
          dmem_we_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TIMEOUT;
          rdata_d     = ERR_RDATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT_R: begin
        if (dmem_rvalid) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_NONE;
          rdata_d     = al_load;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TIMEOUT;
          rdata_d     = ERR_RDATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_lo_q    <= '0;
      f3_q         <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_lo_q    <= addr_lo_d;
      f3_q         <= f3_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign req_ready  = in_idle;
  assign stall      = req_valid & ~rsp_valid_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rdata      = rdata_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a vector table of complete transactions
// with scripted gnt/rvalid timing, plus hand-written reset sequences.
module tb_lsu_mem_ctrl;

  localparam int unsigned TMO  = 4;
  localparam logic [31:0] ERRD = 32'hE0E0_E0E0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, mem_rd, mem_wr;
  logic [2:0]  rw_type;
  logic [31:0] addr, wdata;
  logic        req_ready, stall, rsp_valid;
  logic [1:0]  rsp_err;
  logic [31:0] rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT(TMO), .ERR_RDATA(ERRD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .rw_type(rw_type), .addr(addr), .wdata(wdata),
    .req_ready(req_ready), .stall(stall), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rdata(rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd, mrd;
    int          gnt_c, rv_c;
    int          exp_lat;
    logic [1:0]  exp_err;
    logic [31:0] exp_rdata;
    int          exp_nreq;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: actual %h required %h", nm, id, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                              input int g, input int rv, input int lat, input logic [1:0] err,
                              input logic [31:0] erd, input int nreq, input logic [3:0] be,
                              input logic [31:0] ewd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wd = wd; v.mrd = mrd;
    v.gnt_c = g; v.rv_c = rv; v.exp_lat = lat; v.exp_err = err; v.exp_rdata = erd;
    v.exp_nreq = nreq; v.exp_be = be; v.exp_wd = ewd;
    return v;
  endfunction

  // Called at posedge+1 of an IDLE cycle; that cycle is cycle 0 (acceptance).
  task automatic run_vec(input vec_t v, input int id);
    int          lat, nreq;
    logic        stall_bad, ready_bad, unstable, g_stall;
    logic [31:0] c_addr, c_wd, g_rd;
    logic [3:0]  c_be;
    logic        c_we;
    logic [1:0]  g_err;
    lat = -1; nreq = 0; stall_bad = 0; ready_bad = 0; unstable = 0; g_stall = 1'b1;
    c_addr = '0; c_wd = '0; c_be = '0; c_we = 1'b0; g_err = '0; g_rd = '0;
    mem_rd = v.rd; mem_wr = v.wr; rw_type = v.f3; addr = v.addr; wdata = v.wd;
    dmem_rdata = v.mrd; req_valid = 1'b1;
    #1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (rsp_valid) begin
        lat = c; g_err = rsp_err; g_rd = rdata; g_stall = stall;
        break;
      end
      if (!stall) stall_bad = 1'b1;
      if (req_ready != (c == 0)) ready_bad = 1'b1;
      if (dmem_req) begin
        if (nreq == 0) begin
          c_addr = dmem_addr; c_be = dmem_be; c_wd = dmem_wdata; c_we = dmem_we;
        end else if (c_addr !== dmem_addr || c_be !== dmem_be || c_wd !== dmem_wdata || c_we !== dmem_we) begin
          unstable = 1'b1;
        end
        nreq++;
      end
      dmem_gnt    = (c == v.gnt_c);
      dmem_rvalid = (c == v.rv_c);
    end
    req_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk("rsp_cycle", id, lat, v.exp_lat);
    chk("rsp_err", id, 32'(g_err), 32'(v.exp_err));
    chk("rdata", id, g_rd, v.exp_rdata);
    chk("stall_at_rsp", id, 32'(g_stall), 32'd0);
    chk("stall_before_rsp", id, 32'(stall_bad), 32'd0);
    chk("req_ready", id, 32'(ready_bad), 32'd0);
    chk("req_cycles", id, nreq, v.exp_nreq);
    if (v.exp_nreq > 0) begin
      chk("dmem_addr", id, c_addr, {v.addr[31:2], 2'b00});
      chk("dmem_be", id, 32'(c_be), 32'(v.exp_be));
      chk("dmem_we", id, 32'(c_we), 32'(v.wr));
      chk("req_stable", id, 32'(unstable), 32'd0);
      if (v.wr) chk("dmem_wdata", id, c_wd, v.exp_wd);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    rst_n = 1'b0; req_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; rw_type = '0;
    addr = '0; wdata = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 0, 32'(req_ready), 32'd1);
    chk("rst_dmem_req", 0, 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 0, 32'(dmem_we), 32'd0);
    chk("rst_rsp_valid", 0, 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 0, 32'(rsp_err), 32'd0);
    chk("rst_rdata", 0, rdata, 32'd0);
    chk("rst_dmem_addr", 0, dmem_addr, 32'd0);
    chk("rst_dmem_be", 0, 32'(dmem_be), 32'd0);
    chk("rst_dmem_wdata", 0, dmem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //             rd    wr    f3    addr           wdata          mem rdata      g   rv lat err   rdata          nreq be       wdata
    vq.push_back(mk(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0,         1, -1, 2, 2'd0, 32'h0,         1, 4'b1000, 32'hA5A5_A5A5));
    vq.push_back(mk(1'b1, 1'b0, 3'd0, 32'h0000_2001, 32'h0,         32'h1234_80FF, 1,  2, 3, 2'd0, 32'hFFFF_FF80, 1, 4'b1111, 32'h0));
    vq.push_back(mk(1'b1, 1'b0, 3'd4, 32'h0000_2001, 32'h0,         32'h1234_80FF, 1,  2, 3, 2'd0, 32'h0000_0080, 1, 4'b1111, 32'h0));
    vq.push_back(mk(1'b1, 1'b0, 3'd5, 32'h0000_2002, 32'h0,         32'h1234_80FF, 1,  2, 3, 2'd0, 32'h0000_1234, 1, 4'b1111, 32'h0));
    vq.push_back(mk(1'b1, 1'b0, 3'd1, 32'h0000_2000, 32'h0,         32'h1234_80FF, 1,  2, 3, 2'd0, 32'hFFFF_80FF, 1, 4'b1111, 32'h0));
    vq.push_back(mk(1'b1, 1'b0, 3'd2, 32'h0000_2004, 32'h0,         32'hDEAD_BEEF, 1,  2, 3, 2'd0, 32'hDEAD_BEEF, 1, 4'b1111, 32'h0));
    vq.push_back(mk(1'b1, 1'b0, 3'd0, 32'h0000_2003, 32'h0,         32'h7F00_0000, 1,  2, 3, 2'd0, 32'h0000_007F, 1, 4'b1111, 32'h0));
    vq.push_back(mk(1'b1, 1'b0, 3'd5, 32'h0000_2000, 32'h0,         32'h1234_80FF, 1,  2, 3, 2'd0, 32'h0000_80FF, 1, 4'b1111, 32'h0));
    vq.push_back(mk(1'b0, 1'b1, 3'd2, 32'h0000_5000, 32'h0123_4567, 32'h0,         1, -1, 2, 2'd0, 32'h0,         1, 4'b1111, 32'h0123_4567));
    vq.push_back(mk(1'b0, 1'b1, 3'd1, 32'h0000_6000, 32'h1234_ABCD, 32'h0,         1, -1, 2, 2'd0, 32'h0,         1, 4'b0011, 32'hABCD_ABCD));
    vq.push_back(mk(1'b0, 1'b1, 3'd0, 32'h0000_7001, 32'h1234_5677, 32'h0,         1, -1, 2, 2'd0, 32'h0,         1, 4'b0010, 32'h7777_7777));
    vq.push_back(mk(1'b1, 1'b0, 3'd2, 32'h0000_3002, 32'h0,         32'h0,        -1, -1, 1, 2'd1, ERRD,          0, 4'b0000, 32'h0));
    vq.push_back(mk(1'b1, 1'b1, 3'd2, 32'h0000_3000, 32'h0,         32'h0,        -1, -1, 1, 2'd3, ERRD,          0, 4'b0000, 32'h0));
    vq.push_back(mk(1'b0, 1'b0, 3'd2, 32'h0000_3000, 32'h0,         32'h0,        -1, -1, 1, 2'd3, ERRD,          0, 4'b0000, 32'h0));
    vq.push_back(mk(1'b1, 1'b0, 3'd3, 32'h0000_3000, 32'h0,         32'h0,        -1, -1, 1, 2'd3, ERRD,          0, 4'b0000, 32'h0));
    vq.push_back(mk(1'b1, 1'b0, 3'd6, 32'h0000_3000, 32'h0,         32'h0,        -1, -1, 1, 2'd3, ERRD,          0, 4'b0000, 32'h0));
    vq.push_back(mk(1'b0, 1'b1, 3'd4, 32'h0000_3000, 32'h0,         32'h0,        -1, -1, 1, 2'd3, ERRD,          0, 4'b0000, 32'h0));
    vq.push_back(mk(1'b1, 1'b0, 3'd1, 32'h0000_3001, 32'h0,         32'h0,        -1, -1, 1, 2'd1, ERRD,          0, 4'b0000, 32'h0));
    vq.push_back(mk(1'b0, 1'b1, 3'd1, 32'h0000_3003, 32'h0,         32'h0,        -1, -1, 1, 2'd1, ERRD,          0, 4'b0000, 32'h0));
    vq.push_back(mk(1'b0, 1'b1, 3'd2, 32'h0000_3002, 32'h0,         32'h0,        -1, -1, 1, 2'd1, ERRD,          0, 4'b0000, 32'h0));
    vq.push_back(mk(1'b1, 1'b0, 3'd7, 32'h0000_3003, 32'h0,         32'h0,        -1, -1, 1, 2'd3, ERRD,          0, 4'b0000, 32'h0));
    // Multi-cycle corners: grant timeout, rvalid timeout, late grant at the
    // last allowed cycle, slow rvalid, and rvalid during REQ being ignored.
    vq.push_back(mk(1'b1, 1'b0, 3'd2, 32'h0000_8000, 32'h0,         32'h0,        -1, -1, 5, 2'd2, ERRD,          4, 4'b1111, 32'h0));
    vq.push_back(mk(1'b1, 1'b0, 3'd2, 32'h0000_8000, 32'h0,         32'h0,         1, -1, 6, 2'd2, ERRD,          1, 4'b1111, 32'h0));
    vq.push_back(mk(1'b0, 1'b1, 3'd1, 32'h0000_4002, 32'h0000_BEEF, 32'h0,         4, -1, 5, 2'd0, 32'h0,         4, 4'b1100, 32'hBEEF_BEEF));
    vq.push_back(mk(1'b1, 1'b0, 3'd2, 32'h0000_8004, 32'h0,         32'hCAFE_F00D, 2,  5, 6, 2'd0, 32'hCAFE_F00D, 2, 4'b1111, 32'h0));
    vq.push_back(mk(1'b1, 1'b0, 3'd2, 32'h0000_8008, 32'h0,         32'h1111_2222, 3,  2, 8, 2'd2, ERRD,          3, 4'b1111, 32'h0));

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

    // Reset while the request is outstanding in REQ.
    mem_rd = 1'b1; mem_wr = 1'b0; rw_type = 3'd2; addr = 32'h0000_9000; req_valid = 1'b1;
    @(posedge clk); #1;
    chk("rq_dmem_req", 100, 32'(dmem_req), 32'd1);
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk("rq_rst_dmem_req", 100, 32'(dmem_req), 32'd0);
    chk("rq_rst_dmem_addr", 100, dmem_addr, 32'd0);
    chk("rq_rst_dmem_be", 100, 32'(dmem_be), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset during WAIT_R, then a late gnt/rvalid arriving in IDLE.
    req_valid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    chk("wr_req_ready", 101, 32'(req_ready), 32'd0);
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk("wr_rst_dmem_req", 101, 32'(dmem_req), 32'd0);
    chk("wr_rst_rsp_valid", 101, 32'(rsp_valid), 32'd0);
    chk("wr_rst_req_ready", 101, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_gnt = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
      if (rsp_valid || dmem_req || !req_ready) bad = 1'b1;
    end
    chk("late_rvalid_ignored", 101, 32'(bad), 32'd0);
    chk("late_rsp_err", 101, 32'(rsp_err), 32'd0);
    run_vec(mk(1'b1, 1'b0, 3'd2, 32'h0000_900C, 32'h0, 32'h0BAD_F00D, 1, 2, 3, 2'd0, 32'h0BAD_F00D, 1, 4'b1111, 32'h0), 102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
